// File: rtl/tdm_pkg.sv
// Shared constants and FSM state encoding for the TDM slot demultiplexer.
// The PARITY state exists only when TDM_DEMUX_PARITY_EN is defined.
package tdm_pkg;

  localparam int NUM_SLOTS  = 4;
  localparam int SLOT_IDX_W = 2;

  localparam logic [SLOT_IDX_W-1:0] LAST_SLOT = SLOT_IDX_W'(NUM_SLOTS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECV   = 2'd1
`ifdef TDM_DEMUX_PARITY_EN
    ,
    PARITY = 2'd2
`endif
  } state_t;

endpackage

// File: rtl/tdm_slot_capture.sv
// Shadow register file holding one frame of slots. o_frame is a write-through
// view: the slot being written this cycle already shows the incoming data.
module tdm_slot_capture
  import tdm_pkg::*;
#(
  parameter int SLOT_W = 1
) (
  input  logic                        clock,
  input  logic                        resetn,
  input  logic                        i_we,
  input  logic [SLOT_IDX_W-1:0]       i_idx,
  input  logic [SLOT_W-1:0]           i_data,
  output logic [NUM_SLOTS*SLOT_W-1:0] o_frame
);

  logic [SLOT_W-1:0] r_slot [NUM_SLOTS];

  // NOTE: the shadow file is small and must read as zero after reset, so every
  // entry is cleared explicitly; larger memories would normally be left unreset.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < NUM_SLOTS; k++) r_slot[k] <= '0;
    end else if (i_we) begin
      r_slot[i_idx] <= i_data;
    end
  end

  // NOTE: o_frame gets a default before the loop so no path leaves it unassigned,
  // which keeps this block a pure mux rather than an inferred latch.
  always_comb begin
    o_frame = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      o_frame[k*SLOT_W +: SLOT_W] =
        (i_we && (i_idx == SLOT_IDX_W'(k))) ? i_data : r_slot[k];
    end
  end

endmodule

// File: rtl/tdm_demux_1_to_4.sv
// Reassembles 4-slot TDM frames into parallel channels, updated once per frame.
// Define TDM_DEMUX_PARITY_EN for a fifth even-parity beat per frame.
module tdm_demux_1_to_4
  import tdm_pkg::*;
#(
  parameter int SLOT_W = 1
) (
  input  logic                        clock,
  input  logic                        resetn,
  input  logic [SLOT_W-1:0]           din,
  input  logic                        din_valid,
  input  logic                        frame_start,
  output logic [NUM_SLOTS*SLOT_W-1:0] dout,
  output logic                        dout_valid,
  output logic                        frame_err,
  output logic                        parity_err
);

  state_t                        r_state;
  logic [SLOT_IDX_W-1:0]         r_slot_cnt;
  logic [NUM_SLOTS*SLOT_W-1:0]   r_dout;
  logic                          r_dout_valid;
  logic                          r_frame_err;

  logic                          w_we;
  logic [SLOT_IDX_W-1:0]         w_idx;
  logic [NUM_SLOTS*SLOT_W-1:0]   w_frame;

  // A frame_start beat always lands in slot 0, whatever state we are in.
  always_comb begin
    w_we  = 1'b0;
    w_idx = r_slot_cnt;
    if (din_valid) begin
      if (frame_start) begin
        w_we  = 1'b1;
        w_idx = '0;
      end else if (r_state == RECV) begin
        w_we = 1'b1;
      end
    end
  end

  tdm_slot_capture #(
    .SLOT_W (SLOT_W)
  ) u_capture (
    .clock   (clock),
    .resetn  (resetn),
    .i_we    (w_we),
    .i_idx   (w_idx),
    .i_data  (din),
    .o_frame (w_frame)
  );

`ifdef TDM_DEMUX_PARITY_EN
  logic r_parity_err;
`endif

  // NOTE: all state and outputs use non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state      <= IDLE;
      r_slot_cnt   <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_frame_err  <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_dout_valid <= 1'b0;
      r_frame_err  <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      r_parity_err <= 1'b0;
`endif
      if (din_valid) begin
        case (r_state)
          IDLE: begin
            if (frame_start) begin
              r_slot_cnt <= SLOT_IDX_W'(1);
              r_state    <= RECV;
            end
          end
          RECV: begin
            if (frame_start) begin
              r_frame_err <= 1'b1;
              r_slot_cnt  <= SLOT_IDX_W'(1);
            end else if (r_slot_cnt == LAST_SLOT) begin
              r_slot_cnt <= '0;
`ifdef TDM_DEMUX_PARITY_EN
              r_state    <= PARITY;
`else
              r_dout       <= w_frame;
              r_dout_valid <= 1'b1;
              r_state      <= IDLE;
`endif
            end else begin
              r_slot_cnt <= r_slot_cnt + SLOT_IDX_W'(1);
            end
          end
`ifdef TDM_DEMUX_PARITY_EN
          PARITY: begin
            if (frame_start) begin
              r_frame_err <= 1'b1;
              r_slot_cnt  <= SLOT_IDX_W'(1);
              r_state     <= RECV;
            end else begin
              // Even parity: the check bit equals the XOR of all data bits.
              if (din[0] == ^w_frame) begin
                r_dout       <= w_frame;
                r_dout_valid <= 1'b1;
              end else begin
                r_parity_err <= 1'b1;
              end
              r_state <= IDLE;
            end
          end
`endif
          default: begin
            r_slot_cnt <= '0;
            r_state    <= IDLE;
          end
        endcase
      end
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign frame_err  = r_frame_err;
`ifdef TDM_DEMUX_PARITY_EN
  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_tdm_demux_1_to_4.sv
// Directed self-checking bench for tdm_demux_1_to_4 (SLOT_W=4 by default,
// SLOT_W=1 parity vectors when TDM_DEMUX_PARITY_EN is defined).
module tb_tdm_demux_1_to_4;

`ifdef TDM_DEMUX_PARITY_EN
  localparam int SLOT_W = 1;
`else
  localparam int SLOT_W = 4;
`endif

  logic                  clock;
  logic                  resetn;
  logic [SLOT_W-1:0]     din;
  logic                  din_valid;
  logic                  frame_start;
  logic [4*SLOT_W-1:0]   dout;
  logic                  dout_valid;
  logic                  frame_err;
  logic                  parity_err;

  int n_compared;
  int n_mismatched;

  tdm_demux_1_to_4 #(
    .SLOT_W (SLOT_W)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .din         (din),
    .din_valid   (din_valid),
    .frame_start (frame_start),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .frame_err   (frame_err),
    .parity_err  (parity_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One accepted beat; returns #1 after the sampling edge.
  task automatic beat(input logic fs, input logic [SLOT_W-1:0] d);
    din_valid   = 1'b1;
    frame_start = fs;
    din         = d;
    @(posedge clock);
    #1;
    din_valid   = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    resetn       = 1'b0;
    din          = '0;
    din_valid    = 1'b0;
    frame_start  = 1'b0;
    #12;
    check("rst_dout",       32'(dout),       32'h0);
    check("rst_dout_valid", 32'(dout_valid), 32'h0);
    check("rst_frame_err",  32'(frame_err),  32'h0);
    check("rst_parity_err", 32'(parity_err), 32'h0);
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock);
    #1;

`ifndef TDM_DEMUX_PARITY_EN
    // Basic back-to-back frame
    beat(1'b1, 4'h1);
    beat(1'b0, 4'h2);
    beat(1'b0, 4'h3);
    check("basic_no_early_valid", 32'(dout_valid), 32'h0);
    beat(1'b0, 4'h4);
    check("basic_dout",  32'(dout),       32'h4321);
    check("basic_valid", 32'(dout_valid), 32'h1);
    idle(1);
    check("basic_valid_drop", 32'(dout_valid), 32'h0);
    check("basic_dout_held",  32'(dout),       32'h4321);

    // Premature restart
    beat(1'b1, 4'hA);
    beat(1'b0, 4'hB);
    beat(1'b1, 4'h5);
    check("restart_frame_err",   32'(frame_err), 32'h1);
    check("restart_dout_unchg",  32'(dout),      32'h4321);
    beat(1'b0, 4'h6);
    check("restart_err_drop",    32'(frame_err), 32'h0);
    beat(1'b0, 4'h7);
    beat(1'b0, 4'h8);
    check("restart_dout",  32'(dout),       32'h8765);
    check("restart_valid", 32'(dout_valid), 32'h1);

    // Gaps between beats
    beat(1'b1, 4'h1);
    idle(3);
    beat(1'b0, 4'h2);
    idle(3);
    beat(1'b0, 4'h3);
    idle(3);
    check("gap_no_valid",  32'(dout_valid), 32'h0);
    check("gap_dout_held", 32'(dout),       32'h8765);
    beat(1'b0, 4'h4);
    check("gap_dout",  32'(dout),       32'h4321);
    check("gap_valid", 32'(dout_valid), 32'h1);
    idle(1);
    check("gap_single_pulse", 32'(dout_valid), 32'h0);

    // Reset mid-frame
    beat(1'b1, 4'h9);
    beat(1'b0, 4'h8);
    beat(1'b0, 4'h7);
    resetn = 1'b0;
    #2;
    check("midrst_dout",  32'(dout),       32'h0);
    check("midrst_valid", 32'(dout_valid), 32'h0);
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock);
    #1;
    beat(1'b0, 4'h6);
    check("midrst_stale_discard", 32'(dout_valid), 32'h0);
    beat(1'b1, 4'h9);
    beat(1'b0, 4'h8);
    beat(1'b0, 4'h7);
    beat(1'b0, 4'h6);
    check("midrst_dout",      32'(dout),       32'h6789);
    check("midrst_dout_vld",  32'(dout_valid), 32'h1);

    // Non-start beats while idle are discarded silently
    beat(1'b0, 4'hF);
    check("idle_disc_err",   32'(frame_err),  32'h0);
    beat(1'b0, 4'hF);
    check("idle_disc_valid", 32'(dout_valid), 32'h0);
    check("idle_disc_dout",  32'(dout),       32'h6789);
    beat(1'b1, 4'h1);
    beat(1'b0, 4'h2);
    beat(1'b0, 4'h3);
    beat(1'b0, 4'h4);
    check("idle_disc_frame", 32'(dout),       32'h4321);
    check("idle_disc_fvld",  32'(dout_valid), 32'h1);
    check("idle_disc_nerr",  32'(frame_err),  32'h0);
    check("parity_err_tied", 32'(parity_err), 32'h0);
`else
    // Slots 1,0,1,1 -> XOR = 1, so parity bit 1 matches
    beat(1'b1, 1'b1);
    beat(1'b0, 1'b0);
    beat(1'b0, 1'b1);
    beat(1'b0, 1'b1);
    check("par_wait_valid", 32'(dout_valid), 32'h0);
    beat(1'b0, 1'b1);
    check("par_ok_dout",  32'(dout),       32'hD);
    check("par_ok_valid", 32'(dout_valid), 32'h1);
    check("par_ok_perr",  32'(parity_err), 32'h0);
    idle(1);
    check("par_ok_drop",  32'(dout_valid), 32'h0);

    // Same slots, wrong parity bit
    beat(1'b1, 1'b1);
    beat(1'b0, 1'b0);
    beat(1'b0, 1'b1);
    beat(1'b0, 1'b1);
    beat(1'b0, 1'b0);
    check("par_bad_perr",  32'(parity_err), 32'h1);
    check("par_bad_valid", 32'(dout_valid), 32'h0);
    check("par_bad_dout",  32'(dout),       32'hD);
    idle(1);
    check("par_bad_drop",  32'(parity_err), 32'h0);

    // Restart on the parity beat
    beat(1'b1, 1'b0);
    beat(1'b0, 1'b0);
    beat(1'b0, 1'b0);
    beat(1'b0, 1'b1);
    beat(1'b1, 1'b0);
    check("par_restart_err", 32'(frame_err), 32'h1);
    beat(1'b0, 1'b1);
    beat(1'b0, 1'b0);
    beat(1'b0, 1'b0);
    beat(1'b0, 1'b1);
    check("par_restart_dout", 32'(dout),       32'h2);
    check("par_restart_vld",  32'(dout_valid), 32'h1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
